// File: rtl/dlrom_pkg.sv
// Shared constants and download decode helper for the download ROM banks.
package dlrom_pkg;

  localparam int DL_AW     = 18;
  localparam int MAX_NBANK = 8;

  // True when dl_ad lands in one of the nbank banks starting at base.
  // The bank index wraps at DL_AW-aw bits.
  function automatic logic bank_hit(input logic [DL_AW-1:0] dl_ad, input int base,
                                    input int aw, input int nbank);
    logic [DL_AW-1:0] mask;
    logic [DL_AW-1:0] idx;
    mask = (DL_AW'(1) << (DL_AW - aw)) - DL_AW'(1);
    idx  = ((dl_ad >> aw) - DL_AW'(base)) & mask;
    return idx < DL_AW'(nbank);
  endfunction

endpackage

// File: rtl/dlrom_bank_if.sv
// Read port and download port bundle for dlrom_bank.
// The dl_sum checksum signal exists only when DLROM_CHECKSUM_EN is defined.
interface dlrom_bank_if #(
  parameter int AW = 13,
  parameter int DW = 8
);
  logic          rd_en;
  logic [AW+2:0] rd_ad;
  logic [DW-1:0] rd_dt;
  logic          rd_vld;
  logic          dl_en;
  logic [17:0]   dl_ad;
  logic [7:0]    dl_dt;
  logic          loaded;
  logic [AW+2:0] dl_cnt;
`ifdef DLROM_CHECKSUM_EN
  logic [15:0]   dl_sum;

  modport master (output rd_en, rd_ad, dl_en, dl_ad, dl_dt,
                  input  rd_dt, rd_vld, loaded, dl_cnt, dl_sum);
  modport slave  (input  rd_en, rd_ad, dl_en, dl_ad, dl_dt,
                  output rd_dt, rd_vld, loaded, dl_cnt, dl_sum);
`else
  modport master (output rd_en, rd_ad, dl_en, dl_ad, dl_dt,
                  input  rd_dt, rd_vld, loaded, dl_cnt);
  modport slave  (input  rd_en, rd_ad, dl_en, dl_ad, dl_dt,
                  output rd_dt, rd_vld, loaded, dl_cnt);
`endif
endinterface

// File: rtl/dlrom_ram.sv
// Single-bank simple dual-port RAM with registered read (read-before-write).
module dlrom_ram #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i,
  input  logic          re_i,
  input  logic [AW-1:0] ra_i,
  output logic [DW-1:0] rd_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wa_i] <= wd_i;
    if (re_i) rd_q <= mem_q[ra_i];
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/dlrom_bank.sv
// NBANK download-loaded RAM banks with one pipelined read port and load tracking.
// Define DLROM_CHECKSUM_EN to add the dl_sum running byte checksum.
module dlrom_bank
  import dlrom_pkg::*;
#(
  parameter int         AW    = 13,
  parameter int         DW    = 8,
  parameter int         NBANK = 3,
  parameter int         BASE  = 0,
  parameter int         OREG  = 0,
  parameter logic [7:0] FILL  = 8'h00
) (
  input logic         clk,
  input logic         reset,
  dlrom_bank_if.slave bus
);

  localparam int IW  = DL_AW - AW;
  localparam int CW  = AW + 3;
  localparam int LAT = 1 + OREG;
  // With eight banks the full count does not fit in CW bits; stop one short.
  localparam logic [CW-1:0] CNT_MAX = (NBANK >= MAX_NBANK) ? '1 : CW'(NBANK << AW);

  logic [IW-1:0]    dl_idx;
  logic [AW-1:0]    dl_wa;
  logic [DW-1:0]    dl_wd;
  logic             dl_wr;
  logic             dl_restart;
  logic             dl_top;
  logic [NBANK-1:0] bank_we;
  logic             unused_dl;

  assign dl_idx     = bus.dl_ad[DL_AW-1:AW] - IW'(BASE);
  assign dl_wa      = bus.dl_ad[AW-1:0];
  assign dl_wd      = bus.dl_dt[DW-1:0];
  assign dl_wr      = bus.dl_en && bank_hit(bus.dl_ad, BASE, AW, NBANK);
  assign dl_restart = dl_wr && (dl_idx == '0) && (dl_wa == '0);
  assign dl_top     = dl_wr && (dl_idx == IW'(NBANK - 1)) && (dl_wa == '1);
  assign unused_dl  = ^bus.dl_dt;

  always_comb begin
    for (int k = 0; k < NBANK; k++) bank_we[k] = dl_wr && (dl_idx == IW'(k));
  end

  logic [DW-1:0] ram_rd [MAX_NBANK];

  for (genvar k = 0; k < MAX_NBANK; k++) begin : g_bank
    if (k < NBANK) begin : g_ram
      dlrom_ram #(.AW(AW), .DW(DW)) u_ram (
        .clk_i (clk),
        .we_i  (bank_we[k]),
        .wa_i  (dl_wa),
        .wd_i  (dl_wd),
        .re_i  (bus.rd_en),
        .ra_i  (bus.rd_ad[AW-1:0]),
        .rd_o  (ram_rd[k])
      );
    end else begin : g_fill
      assign ram_rd[k] = FILL[DW-1:0];
    end
  end

  // Download progress.
  logic [CW-1:0] cnt_q, cnt_d;
  logic          loaded_q, loaded_d;

  always_comb begin
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    if (dl_restart) begin
      cnt_d    = CW'(1);
      loaded_d = 1'b0;
    end else if (dl_wr) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      if (dl_top)           loaded_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
    end
  end

  assign bus.dl_cnt = cnt_q;
  assign bus.loaded = loaded_q;

  // Read path. sel_q pairs with the RAM address register; rd_clr_q forces
  // zero on rd_dt until the first read after reset lands.
  logic [2:0]     sel_q;
  logic           rd_clr_q;
  logic [LAT-1:0] vld_q;
  logic [DW-1:0]  stage1;

  always_ff @(posedge clk) begin
    if (bus.rd_en) sel_q <= bus.rd_ad[AW+2:AW];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      rd_clr_q <= 1'b1;
    end else begin
      vld_q <= LAT'({vld_q, bus.rd_en});
      if (bus.rd_en) rd_clr_q <= 1'b0;
    end
  end

  assign stage1     = rd_clr_q ? '0 : ram_rd[sel_q];
  assign bus.rd_vld = vld_q[LAT-1];

  if (OREG != 0) begin : g_oreg
    logic [DW-1:0] out_q;
    always_ff @(posedge clk) begin
      if (reset)         out_q <= '0;
      else if (vld_q[0]) out_q <= stage1;
    end
    assign bus.rd_dt = out_q;
  end else begin : g_noreg
    assign bus.rd_dt = stage1;
  end

`ifdef DLROM_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (dl_restart)  sum_d = 16'(dl_wd);
    else if (dl_wr)  sum_d = sum_q + 16'(dl_wd);
  end

  always_ff @(posedge clk) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign bus.dl_sum = sum_q;
`endif

endmodule

// File: tb/tb_dlrom_bank.sv
// Directed self-checking bench for dlrom_bank (OREG=0 and OREG=1 instances).
module tb_dlrom_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dl_en = 1'b0;
  logic [17:0] dl_ad = '0;
  logic [7:0]  dl_dt = '0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dlrom_bank_if #(.AW(4), .DW(8)) bus0 ();
  dlrom_bank_if #(.AW(4), .DW(8)) bus1 ();

  assign bus0.dl_en = dl_en;
  assign bus0.dl_ad = dl_ad;
  assign bus0.dl_dt = dl_dt;
  assign bus1.dl_en = dl_en;
  assign bus1.dl_ad = dl_ad;
  assign bus1.dl_dt = dl_dt;

  dlrom_bank #(.AW(4), .DW(8), .NBANK(3), .BASE(2), .OREG(0), .FILL(8'h00)) u0 (
    .clk(clk), .reset(reset), .bus(bus0));
  dlrom_bank #(.AW(4), .DW(8), .NBANK(3), .BASE(2), .OREG(1), .FILL(8'hEE)) u1 (
    .clk(clk), .reset(reset), .bus(bus1));

`ifdef DLROM_CHECKSUM_EN
  dlrom_bank_if #(.AW(4), .DW(4)) bus2 ();
  assign bus2.dl_en = dl_en;
  assign bus2.dl_ad = dl_ad;
  assign bus2.dl_dt = dl_dt;
  assign bus2.rd_en = 1'b0;
  assign bus2.rd_ad = '0;
  dlrom_bank #(.AW(4), .DW(4), .NBANK(3), .BASE(2), .OREG(0), .FILL(8'h00)) u2 (
    .clk(clk), .reset(reset), .bus(bus2));
`endif

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dl_wr(input logic [17:0] a, input logic [7:0] d);
    dl_en = 1'b1;
    dl_ad = a;
    dl_dt = d;
    @(negedge clk);
    dl_en = 1'b0;
  endtask

  task automatic rd0(input logic [6:0] a);
    bus0.rd_en = 1'b1;
    bus0.rd_ad = a;
    @(negedge clk);
    bus0.rd_en = 1'b0;
  endtask

  initial begin
    bus0.rd_en = 1'b0;
    bus0.rd_ad = '0;
    bus1.rd_en = 1'b0;
    bus1.rd_ad = '0;
    repeat (3) @(negedge clk);

    chk("rst_rd_dt0", 16'(bus0.rd_dt), 16'h0);
    chk("rst_rd_vld0", 16'(bus0.rd_vld), 16'h0);
    chk("rst_loaded", 16'(bus0.loaded), 16'h0);
    chk("rst_dl_cnt", 16'(bus0.dl_cnt), 16'h0);
    chk("rst_rd_dt1", 16'(bus1.rd_dt), 16'h0);
    chk("rst_rd_vld1", 16'(bus1.rd_vld), 16'h0);
    reset = 1'b0;

    // Load all three banks, byte = low 8 bits of address.
    for (int a = 'h20; a <= 'h4F; a++) begin
      if (a == 'h30) chk("cnt_mid", 16'(bus0.dl_cnt), 16'd16);
      if (a == 'h4F) chk("loaded_before_top", 16'(bus0.loaded), 16'h0);
      dl_wr(18'(a), 8'(a));
    end
    chk("loaded_after_top", 16'(bus0.loaded), 16'h1);
    chk("cnt_full", 16'(bus0.dl_cnt), 16'd48);
    chk("loaded_u1", 16'(bus1.loaded), 16'h1);

    rd0(7'h2A);
    chk("rd_2A", 16'(bus0.rd_dt), 16'h4A);
    chk("rd_2A_vld", 16'(bus0.rd_vld), 16'h1);
    @(negedge clk);
    chk("idle_vld", 16'(bus0.rd_vld), 16'h0);
    chk("idle_hold", 16'(bus0.rd_dt), 16'h4A);

    // Out-of-range downloads are ignored.
    dl_wr(18'h10, 8'h99);
    dl_wr(18'h50, 8'h77);
    chk("oor_cnt", 16'(bus0.dl_cnt), 16'd48);
    rd0(7'h00);
    chk("oor_b0a0", 16'(bus0.rd_dt), 16'h20);
    rd0(7'h20);
    chk("oor_b2a0", 16'(bus0.rd_dt), 16'h40);
    rd0(7'h53);
    chk("fill_dt", 16'(bus0.rd_dt), 16'h00);
    chk("fill_vld", 16'(bus0.rd_vld), 16'h1);

    // OREG=1: back-to-back reads of bank 1 addresses 0..7.
    for (int c = 0; c < 11; c++) begin
      chk($sformatf("pipe_vld_c%0d", c), 16'(bus1.rd_vld), (c >= 2 && c <= 9) ? 16'h1 : 16'h0);
      if (c >= 2 && c <= 9)
        chk($sformatf("pipe_dt_c%0d", c), 16'(bus1.rd_dt), 16'(8'h30 + 8'(c - 2)));
      bus1.rd_en = (c < 8);
      bus1.rd_ad = 7'(8'h10 + 8'(c));
      @(negedge clk);
    end
    bus1.rd_en = 1'b0;

    bus1.rd_en = 1'b1;
    bus1.rd_ad = 7'h35;
    @(negedge clk);
    bus1.rd_en = 1'b0;
    @(negedge clk);
    chk("fill_u1_dt", 16'(bus1.rd_dt), 16'hEE);
    chk("fill_u1_vld", 16'(bus1.rd_vld), 16'h1);

    // Same-cycle write and read: old data first.
    dl_en = 1'b1;
    dl_ad = 18'h23;
    dl_dt = 8'hAA;
    bus0.rd_en = 1'b1;
    bus0.rd_ad = 7'h03;
    @(negedge clk);
    dl_en = 1'b0;
    chk("rbw_old", 16'(bus0.rd_dt), 16'h23);
    @(negedge clk);
    bus0.rd_en = 1'b0;
    chk("rbw_new", 16'(bus0.rd_dt), 16'hAA);
    chk("cnt_sat", 16'(bus0.dl_cnt), 16'd48);
    chk("loaded_hold", 16'(bus0.loaded), 16'h1);

    // Restart.
    dl_wr(18'h20, 8'h20);
    chk("restart_loaded", 16'(bus0.loaded), 16'h0);
    chk("restart_cnt", 16'(bus0.dl_cnt), 16'd1);
    dl_wr(18'h21, 8'h21);
    chk("restart_cnt2", 16'(bus0.dl_cnt), 16'd2);

    // Reset with a read in flight on the OREG instance.
    bus1.rd_en = 1'b1;
    bus1.rd_ad = 7'h2F;
    @(negedge clk);
    bus1.rd_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_vld1", 16'(bus1.rd_vld), 16'h0);
    chk("rst_mid_dt1", 16'(bus1.rd_dt), 16'h0);
    chk("rst_mid_cnt", 16'(bus0.dl_cnt), 16'h0);
    chk("rst_mid_loaded", 16'(bus0.loaded), 16'h0);
    reset = 1'b0;

    rd0(7'h2F);
    chk("keep_b2aF", 16'(bus0.rd_dt), 16'h4F);
    bus1.rd_en = 1'b1;
    bus1.rd_ad = 7'h03;
    @(negedge clk);
    bus1.rd_en = 1'b0;
    @(negedge clk);
    chk("keep_u1_b0a3", 16'(bus1.rd_dt), 16'hAA);

`ifdef DLROM_CHECKSUM_EN
    dl_wr(18'h20, 8'hFF);
    chk("sum_restart", bus2.dl_sum, 16'h000F);
    dl_wr(18'h21, 8'h12);
    chk("sum_2", bus2.dl_sum, 16'h0011);
    dl_wr(18'h22, 8'h03);
    chk("sum_3", bus2.dl_sum, 16'h0014);
    dl_wr(18'h50, 8'h05);
    chk("sum_oor", bus2.dl_sum, 16'h0014);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
